// File: rtl/ahb_bus_arbiter_if.sv
// Arbitration signal bundle shared by the AHB masters' muxed bus and the arbiter.
// The slave modport is the arbiter's view, the master modport is the bus/master side.
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    logic [NUM_MASTERS-1:0]         HBUSREQ;
    logic [NUM_MASTERS-1:0]         HLOCK;
    logic [1:0]                     HTRANS;
    logic [2:0]                     HBURST;
    logic                           HREADY;
    logic                           HRESP;
    logic [NUM_MASTERS-1:0]         HGRANT;
    logic [$clog2(NUM_MASTERS)-1:0] HMASTER;
    logic                           HMASTLOCK;

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
        output HGRANT, HMASTER, HMASTLOCK
    );

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
        input  HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite bus arbiter with burst tracking, locked sequences,
// error-response recovery and parking on DEFAULT_MASTER.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_INCR_BEATS = 16
) (
    input logic              HCLK,
    input logic              HRESET,
    ahb_bus_arbiter_if.slave bus
);
    localparam int IDX_W     = $clog2(NUM_MASTERS);
    localparam int MAX_BEATS = (MAX_INCR_BEATS > 16) ? MAX_INCR_BEATS : 16;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        S_PARK,
        S_BURST,
        S_ERR
    } arbState_t;

    arbState_t              state_q, state_d;
    logic [CNT_W-1:0]       beatCnt_q, beatCnt_d;
    logic [IDX_W-1:0]       rrPtr_q, rrPtr_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       master_q, master_d;
    logic                   mastLock_q, mastLock_d;

    logic [IDX_W-1:0]       ownerIdx;
    logic                   ownerReq;
    logic                   ownerLock;
    logic [NUM_MASTERS-1:0] otherReq;
    logic [NUM_MASTERS-1:0] candReq;
    logic [IDX_W-1:0]       rrWinner;
    logic                   rrFound;
    logic                   arbReq;
    int                     scanPos;

    // Address-phase length of the burst type being started (INCR is capped).
    function automatic logic [CNT_W-1:0] burstLen(input logic [2:0] hburst);
        case (hburst)
            3'b000:         burstLen = CNT_W'(1);
            3'b001:         burstLen = CNT_W'(MAX_INCR_BEATS);
            3'b010, 3'b011: burstLen = CNT_W'(4);
            3'b100, 3'b101: burstLen = CNT_W'(8);
            default:        burstLen = CNT_W'(16);
        endcase
    endfunction

    // Decode the one-hot grant into the index of the owning master.
    always_comb begin
        ownerIdx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                ownerIdx = IDX_W'(i);
            end
        end
    end

    assign ownerReq  = bus.HBUSREQ[ownerIdx];
    assign ownerLock = bus.HLOCK[ownerIdx];

    // Round-robin scan from the pointer; the current owner only competes when
    // nobody else is asking, so a finished owner goes to the back of the line.
    always_comb begin
        otherReq = bus.HBUSREQ & ~grant_q;
        candReq  = (otherReq != '0) ? otherReq : bus.HBUSREQ;
        rrWinner = IDX_W'(DEFAULT_MASTER);
        rrFound  = 1'b0;
        scanPos  = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            scanPos = int'(rrPtr_q) + k;
            if (scanPos >= NUM_MASTERS) begin
                scanPos = scanPos - NUM_MASTERS;
            end
            if (!rrFound && candReq[IDX_W'(scanPos)]) begin
                rrWinner = IDX_W'(scanPos);
                rrFound  = 1'b1;
            end
        end
    end

    // Burst tracking, error handling and grant/pointer update. Everything is
    // frozen while HREADY is low except the jump into the error state.
    always_comb begin
        state_d    = state_q;
        beatCnt_d  = beatCnt_q;
        rrPtr_d    = rrPtr_q;
        grant_d    = grant_q;
        master_d   = master_q;
        mastLock_d = mastLock_q;
        arbReq     = 1'b0;
        if (bus.HRESP && !bus.HREADY) begin
            state_d = S_ERR;
        end else if (bus.HREADY) begin
            master_d   = ownerIdx;
            mastLock_d = ownerLock;
            case (state_q)
                S_PARK: begin
                    if (bus.HTRANS == TRANS_NONSEQ) begin
                        if (burstLen(bus.HBURST) == CNT_W'(1)) begin
                            beatCnt_d = '0;
                            arbReq    = !ownerLock;
                        end else begin
                            beatCnt_d = burstLen(bus.HBURST) - CNT_W'(1);
                            state_d   = S_BURST;
                        end
                    end else begin
                        arbReq = !(ownerLock || ownerReq);
                    end
                end
                S_BURST: begin
                    if (bus.HTRANS == TRANS_NONSEQ || bus.HTRANS == TRANS_SEQ) begin
                        if (beatCnt_q <= CNT_W'(1)) begin
                            beatCnt_d = '0;
                            state_d   = S_PARK;
                            arbReq    = !ownerLock;
                        end else begin
                            beatCnt_d = beatCnt_q - CNT_W'(1);
                        end
                    end else if (bus.HTRANS == TRANS_IDLE) begin
                        beatCnt_d = '0;
                        state_d   = S_PARK;
                        arbReq    = !ownerLock;
                    end
                end
                S_ERR: begin
                    beatCnt_d = '0;
                    state_d   = S_PARK;
                    arbReq    = !ownerLock;
                end
                default: begin
                    state_d = S_PARK;
                end
            endcase
            if (arbReq) begin
                grant_d           = '0;
                grant_d[rrWinner] = 1'b1;
                if (rrWinner != ownerIdx) begin
                    rrPtr_d = (rrWinner == IDX_W'(NUM_MASTERS - 1)) ? '0 : rrWinner + 1'b1;
                end
            end
        end
    end

    // State register; reset parks the bus and abandons any burst in flight.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= S_PARK;
            beatCnt_q  <= '0;
            rrPtr_q    <= '0;
            grant_q    <= NUM_MASTERS'(1) << DEFAULT_MASTER;
            master_q   <= IDX_W'(DEFAULT_MASTER);
            mastLock_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beatCnt_q  <= beatCnt_d;
            rrPtr_q    <= rrPtr_d;
            grant_q    <= grant_d;
            master_q   <= master_d;
            mastLock_q <= mastLock_d;
        end
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HMASTER   = master_q;
    assign bus.HMASTLOCK = mastLock_q;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed testbench for ahb_bus_arbiter: stimulus pushes the expected
// grant/master/lock tuple, a monitor pops and compares after each clock edge.
module tb_ahb_bus_arbiter;
    localparam int NM = 4;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] WRAP4  = 3'b010;
    localparam logic [2:0] INCR4  = 3'b011;
    localparam logic [2:0] INCR8  = 3'b101;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] master;
        logic       lock;
    } expect_t;

    logic clock;
    logic reset;

    expect_t expQ[$];
    string   nameQ[$];
    int      checks   = 0;
    int      failures = 0;

    ahb_bus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

    ahb_bus_arbiter #(
        .NUM_MASTERS   (NM),
        .DEFAULT_MASTER(0),
        .MAX_INCR_BEATS(16)
    ) dut (
        .HCLK  (clock),
        .HRESET(reset),
        .bus   (bus)
    );

    // Free-running bus clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compare the DUT outputs against one expected tuple.
    task automatic checkOutput(input string name, input expect_t e);
        checks++;
        if (bus.HGRANT !== e.grant || bus.HMASTER !== e.master || bus.HMASTLOCK !== e.lock) begin
            failures++;
            $display("[TB] FAIL %s: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                     name, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, e.grant, e.master, e.lock);
        end
    endtask

    // Drive one bus cycle at a falling edge, record what the next rising edge must produce.
    task automatic applyStimulus(input string name, input logic [3:0] req, input logic [3:0] lock,
                                 input logic [1:0] trans, input logic [2:0] burst,
                                 input logic rdy, input logic resp,
                                 input logic [3:0] eGrant, input logic [1:0] eMaster, input logic eLock);
        expect_t e;
        bus.HBUSREQ = req;
        bus.HLOCK   = lock;
        bus.HTRANS  = trans;
        bus.HBURST  = burst;
        bus.HREADY  = rdy;
        bus.HRESP   = resp;
        e.grant  = eGrant;
        e.master = eMaster;
        e.lock   = eLock;
        expQ.push_back(e);
        nameQ.push_back(name);
        @(negedge clock);
    endtask

    // Monitor: after every rising edge, score the oldest outstanding expectation.
    initial begin : monitor
        expect_t e;
        string   n;
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                n = nameQ.pop_front();
                checkOutput(n, e);
            end
        end
    end

    // Hard stop if anything ever stalls.
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        expect_t rv;
        rv.grant  = 4'b0001;
        rv.master = 2'd0;
        rv.lock   = 1'b0;

        reset       = 1'b1;
        bus.HBUSREQ = '0;
        bus.HLOCK   = '0;
        bus.HTRANS  = IDLE;
        bus.HBURST  = SINGLE;
        bus.HREADY  = 1'b1;
        bus.HRESP   = 1'b0;
        #3;
        checkOutput("reset_values", rv);
        @(negedge clock);
        reset = 1'b0;

        // 1: parked on master 0 while nobody requests
        for (int i = 0; i < 10; i++) begin
            applyStimulus("t1_park", 4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0);
        end

        // 2: M1 then M2, INCR4 each, handover on the last accepted beat
        applyStimulus("t2_arb_m1",   4'b0110, 4'b0000, IDLE,   INCR4, 1'b1, 1'b0, 4'b0010, 2'd0, 1'b0);
        applyStimulus("t2_hold_m1",  4'b0110, 4'b0000, IDLE,   INCR4, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0);
        applyStimulus("t2_m1_b1",    4'b0110, 4'b0000, NONSEQ, INCR4, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0);
        applyStimulus("t2_m1_b2",    4'b0110, 4'b0000, SEQ,    INCR4, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0);
        applyStimulus("t2_m1_b3",    4'b0110, 4'b0000, SEQ,    INCR4, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0);
        applyStimulus("t2_m1_b4",    4'b0110, 4'b0000, SEQ,    INCR4, 1'b1, 1'b0, 4'b0100, 2'd1, 1'b0);
        applyStimulus("t2_m2_b1",    4'b0100, 4'b0000, NONSEQ, INCR4, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0);
        applyStimulus("t2_m2_b2",    4'b0100, 4'b0000, SEQ,    INCR4, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0);
        applyStimulus("t2_m2_b3",    4'b0100, 4'b0000, SEQ,    INCR4, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0);
        applyStimulus("t2_m2_b4",    4'b0000, 4'b0000, SEQ,    INCR4, 1'b1, 1'b0, 4'b0001, 2'd2, 1'b0);
        applyStimulus("t2_park",     4'b0000, 4'b0000, IDLE,   INCR4, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0);

        // 3: all four request SINGLE bursts back to back -> 0,1,2,3,0,1
        applyStimulus("t3_hold_m0",  4'b1111, 4'b0000, IDLE,   SINGLE, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0);
        applyStimulus("t3_to_m1",    4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 1'b0, 4'b0010, 2'd0, 1'b0);
        applyStimulus("t3_to_m2",    4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 1'b0, 4'b0100, 2'd1, 1'b0);
        applyStimulus("t3_to_m3",    4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 1'b0, 4'b1000, 2'd2, 1'b0);
        applyStimulus("t3_to_m0",    4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 1'b0, 4'b0001, 2'd3, 1'b0);
        applyStimulus("t3_to_m1b",   4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 1'b0, 4'b0010, 2'd0, 1'b0);
        applyStimulus("t3_park",     4'b0000, 4'b0000, IDLE,   SINGLE, 1'b1, 1'b0, 4'b0001, 2'd1, 1'b0);
        applyStimulus("t3_parked",   4'b0000, 4'b0000, IDLE,   SINGLE, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0);

        // 4: M2 INCR8 with wait states and a BUSY; M0 waits for all 8 beats
        applyStimulus("t4_arb_m2",   4'b0100, 4'b0000, IDLE,   INCR8, 1'b1, 1'b0, 4'b0100, 2'd0, 1'b0);
        applyStimulus("t4_b1",       4'b0101, 4'b0000, NONSEQ, INCR8, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0);
        applyStimulus("t4_b2",       4'b0101, 4'b0000, SEQ,    INCR8, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0);
        applyStimulus("t4_wait1",    4'b0101, 4'b0000, SEQ,    INCR8, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0);
        applyStimulus("t4_wait2",    4'b0101, 4'b0000, SEQ,    INCR8, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0);
        applyStimulus("t4_b3",       4'b0101, 4'b0000, SEQ,    INCR8, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0);
        applyStimulus("t4_busy",     4'b0101, 4'b0000, BUSY,   INCR8, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0);
        applyStimulus("t4_b4",       4'b0101, 4'b0000, SEQ,    INCR8, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0);
        applyStimulus("t4_b5",       4'b0101, 4'b0000, SEQ,    INCR8, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0);
        applyStimulus("t4_b6",       4'b0101, 4'b0000, SEQ,    INCR8, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0);
        applyStimulus("t4_b7",       4'b0101, 4'b0000, SEQ,    INCR8, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0);
        applyStimulus("t4_b8_wait",  4'b0101, 4'b0000, SEQ,    INCR8, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0);
        applyStimulus("t4_b8",       4'b0101, 4'b0000, SEQ,    INCR8, 1'b1, 1'b0, 4'b0001, 2'd2, 1'b0);
        applyStimulus("t4_park",     4'b0000, 4'b0000, IDLE,   INCR8, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0);

        // 5: M1 locked over two INCR4 bursts, M3 waits until the unlocked burst ends
        applyStimulus("t5_arb_m1",   4'b1010, 4'b0010, IDLE,   INCR4, 1'b1, 1'b0, 4'b0010, 2'd0, 1'b0);
        applyStimulus("t5_a_b1",     4'b1010, 4'b0010, NONSEQ, INCR4, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1);
        applyStimulus("t5_a_b2",     4'b1010, 4'b0010, SEQ,    INCR4, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1);
        applyStimulus("t5_a_b3",     4'b1010, 4'b0010, SEQ,    INCR4, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1);
        applyStimulus("t5_a_b4",     4'b1010, 4'b0010, SEQ,    INCR4, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1);
        applyStimulus("t5_b_b1",     4'b1010, 4'b0010, NONSEQ, INCR4, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1);
        applyStimulus("t5_b_b2",     4'b1010, 4'b0010, SEQ,    INCR4, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1);
        applyStimulus("t5_b_b3",     4'b1010, 4'b0010, SEQ,    INCR4, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1);
        applyStimulus("t5_b_b4",     4'b1010, 4'b0010, SEQ,    INCR4, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1);
        applyStimulus("t5_c_b1",     4'b1010, 4'b0000, NONSEQ, INCR4, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0);
        applyStimulus("t5_c_b2",     4'b1010, 4'b0000, SEQ,    INCR4, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0);
        applyStimulus("t5_c_b3",     4'b1010, 4'b0000, SEQ,    INCR4, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0);
        applyStimulus("t5_c_b4",     4'b1010, 4'b0000, SEQ,    INCR4, 1'b1, 1'b0, 4'b1000, 2'd1, 1'b0);
        applyStimulus("t5_hold_m3",  4'b1000, 4'b0000, IDLE,   INCR4, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0);
        applyStimulus("t5_park",     4'b0000, 4'b0000, IDLE,   INCR4, 1'b1, 1'b0, 4'b0001, 2'd3, 1'b0);
        applyStimulus("t5_parked",   4'b0000, 4'b0000, IDLE,   INCR4, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0);

        // 6: error two-cycle response on beat 2 of WRAP4, then an async reset mid-burst
        applyStimulus("t6_arb_m2",   4'b1100, 4'b0000, IDLE,   WRAP4, 1'b1, 1'b0, 4'b0100, 2'd0, 1'b0);
        applyStimulus("t6_b1",       4'b1100, 4'b0000, NONSEQ, WRAP4, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0);
        applyStimulus("t6_err1",     4'b1100, 4'b0000, SEQ,    WRAP4, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b0);
        applyStimulus("t6_err2",     4'b1100, 4'b0000, SEQ,    WRAP4, 1'b1, 1'b1, 4'b1000, 2'd2, 1'b0);
        applyStimulus("t6_hold_m3",  4'b1000, 4'b0000, IDLE,   INCR4, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0);
        applyStimulus("t6_m3_b1",    4'b1000, 4'b0000, NONSEQ, INCR4, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0);
        applyStimulus("t6_m3_b2",    4'b1000, 4'b0000, SEQ,    INCR4, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0);

        bus.HTRANS = IDLE;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_async_reset", rv);
        @(negedge clock);
        reset = 1'b0;

        applyStimulus("t6_rearb_m3", 4'b1000, 4'b0000, IDLE,   INCR4, 1'b1, 1'b0, 4'b1000, 2'd0, 1'b0);
        applyStimulus("t6_abandon",  4'b0000, 4'b0000, SEQ,    INCR4, 1'b1, 1'b0, 4'b0001, 2'd3, 1'b0);
        applyStimulus("t6_parked",   4'b0000, 4'b0000, IDLE,   INCR4, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0);

        for (int w = 0; w < 10 && expQ.size() > 0; w++) begin
            @(negedge clock);
        end
        if (expQ.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
